// File: rtl/data_mem_resp_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
// No logic here; imported by data_mem_resp and data_ram_array users.
package data_mem_resp_pkg;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/data_ram_array.sv
// Single-port word RAM: one-cycle registered read, read-during-write returns old data.
// No backpressure; contents are not reset.
module data_ram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Memory responder: accept in IDLE, WAIT_STATES cycles, one-cycle ready in RESP; stalls pipeline meanwhile.
// Optional MEM_ERR_CHECK_EN flags misaligned or out-of-range addresses (ADDR_W <= 29).
module data_mem_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        stall_req_o
);
  import data_mem_resp_pkg::*;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              req_we, req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       req_data;
  logic [31:0]       data_q, ram_rdata, resp_data;
  logic              in_err, accept, enter_resp;
  logic              cur_we, cur_err, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

`ifdef MEM_ERR_CHECK_EN
  assign in_err = (mem_addr_i[1:0] != 2'b00) || ((mem_addr_i >> (ADDR_W + 2)) != ZeroWord);
`else
  logic unused_addr_bits;
  assign in_err = 1'b0;
  assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};
`endif

  assign accept = (state == ST_IDLE) && (mem_ce_i == ChipEnable);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt <= 4'd1) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);

  // With zero wait states the RAM edge coincides with acceptance, so use the live request in IDLE.
  assign cur_we    = (state == ST_IDLE) ? (mem_we_i == WriteEnable) : req_we;
  assign cur_err   = (state == ST_IDLE) ? in_err : req_err;
  assign ram_addr  = (state == ST_IDLE) ? mem_addr_i[ADDR_W+1:2] : req_idx;
  assign ram_wdata = (state == ST_IDLE) ? mem_data_i : req_data;
  assign ram_we    = rst && enter_resp && cur_we && !cur_err;

  data_ram_array #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      req_we   <= WriteDisable;
      req_err  <= 1'b0;
      req_idx  <= '0;
      req_data <= ZeroWord;
      data_q   <= ZeroWord;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= 4'(WAIT_STATES);
        req_we   <= (mem_we_i == WriteEnable);
        req_err  <= in_err;
        req_idx  <= mem_addr_i[ADDR_W+1:2];
        req_data <= mem_data_i;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ST_RESP) data_q <= resp_data;
    end
  end

  assign resp_data   = (req_we || req_err) ? ZeroWord : ram_rdata;
  assign mem_ready_o = (state == ST_RESP);
  assign mem_data_o  = mem_ready_o ? resp_data : data_q;
  assign stall_req_o = ((state == ST_IDLE) && (mem_ce_i != ChipDisable)) || (state == ST_WAIT);

`ifdef MEM_ERR_CHECK_EN
  assign mem_err_o = mem_ready_o && req_err;
`else
  assign mem_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: dut_a has one wait state, dut_b has none; a scoreboard per DUT checks responses.
module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ce_a, we_a, ready_a, err_a, stall_a;
  logic [31:0] addr_a, wdat_a, rdata_a;
  logic        ce_b, we_b, ready_b, err_b, stall_b;
  logic [31:0] addr_b, wdat_b, rdata_b;

  data_mem_resp #(.ADDR_W(10), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst(rst), .mem_ce_i(ce_a), .mem_we_i(we_a), .mem_addr_i(addr_a),
    .mem_data_i(wdat_a), .mem_data_o(rdata_a), .mem_ready_o(ready_a),
    .mem_err_o(err_a), .stall_req_o(stall_a)
  );

  data_mem_resp #(.ADDR_W(10), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_ce_i(ce_b), .mem_we_i(we_b), .mem_addr_i(addr_b),
    .mem_data_i(wdat_b), .mem_data_o(rdata_b), .mem_ready_o(ready_b),
    .mem_err_o(err_b), .stall_req_o(stall_b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Issue one request starting just after a rising edge; hold it through RESP, drop it after.
  task automatic acc(input bit sel, input bit we, input logic [31:0] addr, input logic [31:0] wdat,
                     input logic [31:0] exp_data, input bit exp_err, input int ws);
    int cyc    = 0;
    int stalls = 0;
    bit got    = 1'b0;
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    if (sel) begin
      q_b.push_back(e);
      ce_b = 1'b1; we_b = we; addr_b = addr; wdat_b = wdat;
    end else begin
      q_a.push_back(e);
      ce_a = 1'b1; we_a = we; addr_a = addr; wdat_a = wdat;
    end
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (sel ? stall_b : stall_a) stalls++;
      if (sel ? ready_b : ready_a) got = 1'b1;
    end
    chk("response_seen", 32'(got), 32'd1);
    chk("ready_latency", 32'(cyc), 32'(ws + 2));
    chk("stall_cycles", 32'(stalls), 32'(ws + 1));
    @(posedge clk);
    #1;
    if (sel) ce_b = 1'b0;
    else     ce_a = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && ready_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_extra_ready: actual unexpected response, required none");
      end else begin
        e_a = q_a.pop_front();
        chk("a_data", rdata_a, e_a.data);
        chk("a_err", {31'b0, err_a}, {31'b0, e_a.err});
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && ready_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_extra_ready: actual unexpected response, required none");
      end else begin
        e_b = q_b.pop_front();
        chk("b_data", rdata_b, e_b.data);
        chk("b_err", {31'b0, err_b}, {31'b0, e_b.err});
      end
    end
  end

  initial begin
    rst = 1'b0;
    ce_a = 1'b0; we_a = 1'b0; addr_a = '0; wdat_a = '0;
    ce_b = 1'b0; we_b = 1'b0; addr_b = '0; wdat_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", {31'b0, ready_a}, 32'd0);
    chk("rst_a_err",   {31'b0, err_a},   32'd0);
    chk("rst_a_stall", {31'b0, stall_a}, 32'd0);
    chk("rst_a_data",  rdata_a,          32'd0);
    chk("rst_b_ready", {31'b0, ready_b}, 32'd0);
    chk("rst_b_data",  rdata_b,          32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: store then load back.
    acc(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1);
    acc(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1);

`ifdef MEM_ERR_CHECK_EN
    acc(0, 1'b1, 32'h0000_0013, 32'hBAD0_BAD0, 32'h0,         1'b1, 1);
    acc(0, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1, 1);
    acc(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1);
`else
    acc(0, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0,         1'b0, 1);
    acc(0, 1'b0, 32'h0000_1004, 32'h0,         32'hA5A5_A5A5, 1'b0, 1);
`endif

    // Zero wait states: preload then back-to-back loads.
    acc(1, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0, 0);
    acc(1, 1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0,         1'b0, 0);
    acc(1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0, 0);
    acc(1, 1'b0, 32'h0000_0004, 32'h0,         32'h2222_2222, 1'b0, 0);

    // Reset during WAIT of a store must abandon it.
    acc(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b0, 1);
    acc(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1);
    ce_a = 1'b1; we_a = 1'b1; addr_a = 32'h0000_0020; wdat_a = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    chk("pre_rst_stall_wait", {31'b0, stall_a}, 32'd1);
    ce_a = 1'b0;
    rst  = 1'b0;
    #1;
    chk("mid_rst_a_ready", {31'b0, ready_a}, 32'd0);
    chk("mid_rst_a_err",   {31'b0, err_a},   32'd0);
    chk("mid_rst_a_stall", {31'b0, stall_a}, 32'd0);
    chk("mid_rst_a_data",  rdata_a,          32'd0);
    chk("mid_rst_b_data",  rdata_b,          32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    acc(0, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
